// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: shares one external full_adder across WIDTH bits,
// LSB first, one bit per clock, with valid/ready request and response handshakes.
//
// state  | meaning
// IDLE   | waiting for a request; start_ready high, adder quiescent
// RUN    | one operand bit per clock through the shared full_adder
// DONE   | result held on sum/cout until the consumer accepts it
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             fa_in1,
    output logic             fa_in2,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               start_fire;
    logic               sum_fire;
    logic               last_bit;

    assign start_fire = start_valid && start_ready;
    assign sum_fire   = sum_valid && sum_ready;
    assign last_bit   = (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Adder inputs stay at zero outside RUN so the shared full_adder is quiet.
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        sum_valid   = 1'b0;
        fa_in1      = 1'b0;
        fa_in2      = 1'b0;
        fa_cin      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_fire) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                fa_in1 = a_sh[0];
                fa_in2 = b_sh[0];
                fa_cin = carry_reg;
                if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                sum_valid = 1'b1;
                if (sum_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_reg <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_fire) begin
                        a_sh      <= op_a;
                        b_sh      <= op_b;
                        sum_sh    <= '0;
                        carry_reg <= cin;
                        bit_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    // Sum bits enter at the MSB so bit 0 lands at the bottom after WIDTH shifts.
                    a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
                    sum_sh    <= {fa_sum, sum_sh[WIDTH-1:1]};
                    carry_reg <= fa_carry;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign sum  = sum_sh;
    assign cout = carry_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vector table, hand-written
// corner sequences, and random back-to-back traffic against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sum_valid;
    logic         sum_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         fa_in1;
    logic         fa_in2;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_carry;

    int n_checks = 0;
    int n_pass   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy),
        .fa_in1      (fa_in1),
        .fa_in2      (fa_in2),
        .fa_cin      (fa_cin),
        .fa_sum      (fa_sum),
        .fa_carry    (fa_carry)
    );

    // The shared full_adder the controller drives.
    assign fa_sum   = fa_in1 ^ fa_in2 ^ fa_cin;
    assign fa_carry = (fa_in1 & fa_in2) | (fa_in1 & fa_cin) | (fa_in2 & fa_cin);

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    // Carry entering each bit position = bit j of the sum of the lower j bits plus cin.
    function automatic logic [W-1:0] carry_in_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic c);
        logic [W-1:0] v;
        logic [W-1:0] m;
        logic [W:0]   s;
        v = '0;
        for (int j = 0; j < W; j++) begin
            m = (W'(1) << j) - W'(1);
            s = {1'b0, a & m} + {1'b0, b & m} + (W+1)'(c);
            v[j] = s[j];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output bit ok);
        op_a = a;
        op_b = b;
        cin = c;
        start_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (start_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        else chk("issue_timeout_start_ready", 64'(start_ready), 64'd1);
        start_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic [W-1:0] es, input logic ec,
                           input bit release_res);
        logic [W-1:0] f1, f2, fc;
        int lat;
        bit busy_ok;
        f1 = '0; f2 = '0; fc = '0;
        lat = 0;
        busy_ok = 1'b1;
        while (!sum_valid && lat < 40) begin
            if (lat < W) begin
                f1[lat] = fa_in1;
                f2[lat] = fa_in2;
                fc[lat] = fa_cin;
            end
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(W));
        chk({tag, "_busy_run"}, 64'(busy_ok & busy), 64'd1);
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_fa_in1_seq"}, 64'(f1), 64'(a));
        chk({tag, "_fa_in2_seq"}, 64'(f2), 64'(b));
        chk({tag, "_fa_cin_seq"}, 64'(fc), 64'(carry_in_vec(a, b, c)));
        chk({tag, "_done_quiet"}, 64'({start_ready, fa_in1, fa_in2, fa_cin}), 64'd0);
        if (release_res) begin
            sum_ready = 1'b1;
            tick();
            sum_ready = 1'b0;
            chk({tag, "_idle_after"},
                64'({sum_valid, busy, start_ready, fa_in1, fa_in2, fa_cin}), 64'b001000);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] es, input logic ec);
        bit ok;
        issue(a, b, c, ok);
        if (ok) collect(tag, a, b, c, es, ec, 1'b1);
    endtask

    initial begin
        logic [W:0]   r;
        logic [W-1:0] ra[16];
        logic [W-1:0] rb[16];
        logic         rc[16];
        int           acc[16];
        logic [W:0]   exp_q[$];
        int           n, got, cyc, bad_iv;
        bit           adv, ok, bp_ok;

        vecs[0] = '{"basic_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{"carry_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{"carry_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{"cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{"fa_seq_01_80", 8'h01, 8'h80, 1'b0, 8'h81, 1'b0};

        repeat (3) tick();
        sys_rst = 1'b0;
        chk("reset_ctrl", 64'({start_ready, sum_valid, busy}), 64'b100);
        chk("reset_sum", 64'({cout, sum}), 64'd0);
        chk("reset_fa", 64'({fa_in1, fa_in2, fa_cin}), 64'd0);
        tick();

        for (int i = 0; i < 5; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_sum, vecs[i].exp_cout);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a, b;
            logic c;
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            r = ref_add(a, b, c);
            run_op("rand_single", a, b, c, r[W-1:0], r[W]);
        end

        // Backpressure: result held while a new request waits.
        issue(8'hC3, 8'h3D, 1'b1, ok);
        if (ok) collect("bp_first", 8'hC3, 8'h3D, 1'b1, 8'h01, 1'b1, 1'b0);
        op_a = 8'h11;
        op_b = 8'h22;
        cin = 1'b0;
        start_valid = 1'b1;
        bp_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({sum_valid, start_ready, cout, sum} !== {1'b1, 1'b0, 1'b1, 8'h01}) bp_ok = 1'b0;
        end
        chk("bp_hold_stable", 64'(bp_ok), 64'd1);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("bp_idle_after_release", 64'({sum_valid, start_ready, busy}), 64'b010);
        tick();
        start_valid = 1'b0;
        chk("bp_new_accept", 64'({busy, start_ready}), 64'b10);
        collect("bp_second", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b1);

        // Reset after three bits of a RUN.
        issue(8'hAA, 8'h55, 1'b0, ok);
        repeat (3) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("midrst_ctrl", 64'({sum_valid, busy, start_ready}), 64'b001);
        chk("midrst_sum", 64'({cout, sum}), 64'd0);
        run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Back-to-back traffic with both handshakes tied high.
        for (int i = 0; i < 16; i++) begin
            ra[i] = W'($urandom);
            rb[i] = W'($urandom);
            rc[i] = 1'($urandom);
        end
        n = 0; got = 0; cyc = 0;
        sum_ready = 1'b1;
        op_a = ra[0]; op_b = rb[0]; cin = rc[0];
        start_valid = 1'b1;
        while (cyc < 400) begin
            if (sum_valid) begin
                if (exp_q.size() > 0) begin
                    chk("b2b_result", 64'({cout, sum}), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                    got++;
                end else begin
                    chk("b2b_spurious_valid", 64'(sum_valid), 64'd0);
                end
            end
            adv = 1'b0;
            if (start_ready && n < 16) begin
                acc[n] = cyc;
                exp_q.push_back(ref_add(ra[n], rb[n], rc[n]));
                adv = 1'b1;
            end
            tick();
            cyc++;
            if (adv) begin
                n++;
                if (n < 16) begin
                    op_a = ra[n]; op_b = rb[n]; cin = rc[n];
                end else begin
                    start_valid = 1'b0;
                end
            end
            if (n == 16 && got == 16) break;
        end
        sum_ready = 1'b0;
        start_valid = 1'b0;
        chk("b2b_result_count", 64'(got), 64'd16);
        bad_iv = 0;
        for (int i = 1; i < n; i++)
            if (acc[i] - acc[i-1] != W + 2) bad_iv++;
        chk("b2b_accept_interval_errors", 64'(bad_iv), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial addition controller that time-multiplexes one external full_adder instance over WIDTH-bit operands, LSB first, one bit per clock.
- Accepts an operation via a valid/ready request handshake and holds operands in shift registers.
- Drives the full_adder inputs, collects its sum bit and registers its carry.
- Returns the WIDTH-bit result and carry-out via a valid/ready response handshake.
- Sits between an operand producer and the shared full_adder; the top level wires fa_* ports directly to full_adder in1/in2/cin/sum/carry, with no logic between them.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- start_valid  in  1  request valid.
- start_ready  out  1  request ready; high only in IDLE.
- op_a  in  WIDTH  operand A; sampled on request handshake.
- op_b  in  WIDTH  operand B; sampled on request handshake.
- cin  in  1  carry-in; sampled on request handshake.
- sum_valid  out  1  result valid; high only in DONE.
- sum_ready  in  1  result accepted by consumer.
- sum  out  WIDTH  registered result.
- cout  out  1  registered carry-out.
- busy  out  1  high when state is not IDLE.
- fa_in1  out  1  to full_adder in1.
- fa_in2  out  1  to full_adder in2.
- fa_cin  out  1  to full_adder cin.
- fa_sum  in  1  from full_adder sum (combinational).
- fa_carry  in  1  from full_adder carry (combinational).

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst is synchronous, active-high.
- Reset values: state=IDLE; a_sh, b_sh, sum_sh, carry_reg, bit_cnt all 0; start_ready=1 after reset release; sum_valid=0; busy=0; sum=0; cout=0; fa_in1/fa_in2/fa_cin=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready at edge k: a_sh<=op_a, b_sh<=op_b, carry_reg<=cin, bit_cnt<=0, sum_sh<=0, state<=RUN.
  - start_valid without the handshake changes nothing.
- RUN:
  - Combinational outputs: fa_in1=a_sh[0], fa_in2=b_sh[0], fa_cin=carry_reg.
  - Each edge: a_sh and b_sh shift right by 1 (0 into MSB); sum_sh shifts right with fa_sum into MSB; carry_reg<=fa_carry; bit_cnt<=bit_cnt+1.
  - Bit i is computed in the cycle after edge k+i and captured at edge k+1+i.
  - At the edge where bit_cnt==WIDTH-1: state<=DONE.
  - Result: sum_sh holds {bit WIDTH-1 .. bit 0}; carry_reg holds the final carry.
- DONE:
  - sum_valid=1, sum=sum_sh, cout=carry_reg.
  - sum and cout are held stable until the handshake.
  - fa_in1/fa_in2/fa_cin=0.
  - On sum_valid&&sum_ready: state<=IDLE.
- Latency: request handshake at edge k, so sum_valid is high from the cycle after edge k+WIDTH. This is WIDTH cycles in RUN.
- Throughput: one operation per WIDTH+2 cycles when sum_ready is held high.
- Outside RUN, fa_* outputs are forced to 0 so the shared adder is quiescent.
- sum and cout outputs are registered (sum_sh/carry_reg), not combinational from fa_*.
- Simultaneous events:
  - Result handshake and new request in the same cycle: the request is not accepted, since start_ready=0 in DONE. It is accepted in the next cycle (IDLE).
  - start_valid during RUN or DONE: ignored; operands are not resampled.
- Reset mid-operation (RUN or DONE):
  - Return to IDLE with all registers cleared.
  - The partial or pending result is discarded; sum_valid drops the cycle after the reset edge.
- Carry wrap: cout is the true carry out of bit WIDTH-1. sum is modulo 2^WIDTH.
- bit_cnt width is $clog2(WIDTH)+1 so the count cannot overflow.

Test Plan:
- Basic add, WIDTH=8: handshake with op_a=0x5A, op_b=0x3C, cin=0 -> sum_valid rises exactly 8 cycles after acceptance; sum=0x96, cout=0; busy high for the whole operation.
- Carry propagation:
  - 0xFF+0x01, cin=0 -> sum=0x00, cout=1.
  - 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1.
  - 0x00+0x00, cin=1 -> sum=0x01, cout=0.
- fa_* sequencing: op_a=0x01, op_b=0x80, cin=0 ->
  - RUN cycle 0: fa_in1=1, fa_in2=0.
  - RUN cycle 7: fa_in1=0, fa_in2=1.
  - fa_in1/fa_in2/fa_cin are all 0 in IDLE and DONE.
  - Final sum=0x81.
- Backpressure: sum_ready held low 5 cycles in DONE with start_valid=1 and new operands -> sum/cout stable, start_ready=0, no resample. Raise sum_ready -> IDLE next cycle, new request accepted the cycle after.
- Reset mid-RUN: assert sys_rst after 3 bits of 0xAA+0x55 -> next cycle state IDLE, sum_valid=0, sum=0, start_ready=1. A following 0x12+0x34 produces 0x46, cout=0.
- Back-to-back, sum_ready and start_valid tied high: 16 random operand pairs -> results match a golden model; requests are accepted every 10 cycles.
